dsp_adder_arbiter: RTL and testbench

//  Shares the single DSPadder instance (combinational, 32-bit, no carry-in) between
//  NUM_REQ requesters, e.g. the ALU and the branch-target path.

---
 rtl/dsp_adder_arbiter.sv | 131 +++++++++++++
 tb/tb_dsp_adder_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_adder_arbiter.sv
// Round-robin front end for a shared combinational DSP adder. Accepts one request
// at a time, registers the operands feeding the adder and returns the captured sum.
module dsp_adder_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_sub,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [WIDTH-1:0]         resp_sum,
    output logic [WIDTH-1:0]         adder_in1,
    output logic [WIDTH-1:0]         adder_in2,
    input  logic [WIDTH-1:0]         adder_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   rr_ptr_reg;
    logic [ID_W-1:0]   id_reg;
    logic [WIDTH-1:0]  op_a_reg;
    logic [WIDTH-1:0]  op_b_reg;
    logic [WIDTH-1:0]  resp_sum_reg;
    logic [ID_W-1:0]   resp_id_reg;

    logic [WIDTH-1:0]  a_arr [NUM_REQ];
    logic [WIDTH-1:0]  b_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Search order starts at rr_ptr and wraps around the requester set.
    function automatic int wrap_idx(input int base, input int offs);
        int s;
        s = base + offs;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s;
    endfunction

    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0] valid_shifted;

    always_comb begin
        grant_found   = 1'b0;
        grant_idx     = '0;
        valid_shifted = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            valid_shifted = req_valid >> wrap_idx(int'(rr_ptr_reg), k);
            if (!grant_found && valid_shifted[0]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(wrap_idx(int'(rr_ptr_reg), k));
            end
        end
    end

    logic accept;
    logic resp_done;

    assign accept    = (state_reg == IDLE) && grant_found;
    assign resp_done = (state_reg == RESP) && resp_ready;
    assign req_ready = (accept && !reset) ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_found) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operands are latched only on accept, so they stay put through EXEC and RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_reg   <= '0;
            id_reg       <= '0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            resp_sum_reg <= '0;
            resp_id_reg  <= '0;
        end else begin
            if (accept) begin
                op_a_reg <= a_arr[grant_idx];
                op_b_reg <= req_sub[grant_idx] ? (~b_arr[grant_idx] + WIDTH'(1))
                                               : b_arr[grant_idx];
                id_reg   <= grant_idx;
            end
            if (state_reg == EXEC) begin
                resp_sum_reg <= adder_out;
                resp_id_reg  <= id_reg;
            end
            if (resp_done) begin
                rr_ptr_reg <= (id_reg == ID_W'(NUM_REQ-1)) ? '0 : id_reg + 1'b1;
            end
        end
    end

    assign adder_in1  = op_a_reg;
    assign adder_in2  = op_b_reg;
    assign resp_valid = (state_reg == RESP);
    assign resp_sum   = resp_sum_reg;
    assign resp_id    = resp_id_reg;

endmodule

// File: tb/tb_dsp_adder_arbiter.sv
// Directed bench for dsp_adder_arbiter; the shared adder is modelled as a plain
// combinational sum of the two registered operands.
module tb_dsp_adder_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  req_sub;
    logic        resp_valid;
    logic        resp_ready;
    logic [0:0]  resp_id;
    logic [31:0] resp_sum;
    logic [31:0] adder_in1;
    logic [31:0] adder_in2;
    logic [31:0] adder_out;

    int total = 0;
    int bad   = 0;

    dsp_adder_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sub    (req_sub),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .adder_in1  (adder_in1),
        .adder_in2  (adder_in2),
        .adder_out  (adder_out)
    );

    assign adder_out = adder_in1 + adder_in2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                           input logic sub);
        req_a[r*32 +: 32] = a;
        req_b[r*32 +: 32] = b;
        req_sub[r]        = sub;
    endtask

    typedef struct {
        int          r;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] exp_opb;
        logic [31:0] exp_sum;
    } vec_t;

    vec_t vecs [7];
    logic [31:0] sums_a [2];
    logic [31:0] held_sum;

    initial begin
        vecs[0] = '{0, 32'd1000,       32'd10,         1'b0, 32'd10,         32'd1010};
        vecs[1] = '{1, 32'd0,          32'd1,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF};
        vecs[2] = '{1, 32'hFFFF_FFFF,  32'd1,          1'b0, 32'd1,          32'd0};
        vecs[3] = '{0, 32'd5,          32'd0,          1'b1, 32'd0,          32'd5};
        vecs[4] = '{1, 32'd0,          32'h8000_0000,  1'b1, 32'h8000_0000,  32'h8000_0000};
        vecs[5] = '{0, 32'd7,          32'd9,          1'b1, 32'hFFFF_FFF7,  32'hFFFF_FFFE};
        vecs[6] = '{1, 32'h1234_5678,  32'h1111_1111,  1'b0, 32'h1111_1111,  32'h2345_6789};

        reset      = 1'b1;
        req_valid  = 2'b11;
        req_a      = '0;
        req_b      = '0;
        req_sub    = 2'b00;
        resp_ready = 1'b0;

        // Reset held two cycles with both requesters asking.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("rst_adder_in1", adder_in1, 32'd0);
            chk("rst_adder_in2", adder_in2, 32'd0);
            chk("rst_resp_sum", resp_sum, 32'd0);
            chk("rst_resp_id", 32'(resp_id), 32'd0);
        end
        req_valid = 2'b00;
        reset     = 1'b0;

        // Single-requester vectors: accept, EXEC, RESP, handshake.
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            set_req(vecs[v].r, vecs[v].a, vecs[v].b, vecs[v].sub);
            req_valid  = 2'b01 << vecs[v].r;
            resp_ready = 1'b1;
            #1;
            chk("vec_req_ready", 32'(req_ready), 32'(2'b01 << vecs[v].r));
            chk("vec_idle_resp_valid", 32'(resp_valid), 32'd0);
            @(negedge clk);
            req_valid = 2'b00;
            #1;
            chk("vec_exec_resp_valid", 32'(resp_valid), 32'd0);
            chk("vec_adder_in1", adder_in1, vecs[v].a);
            chk("vec_adder_in2", adder_in2, vecs[v].exp_opb);
            @(negedge clk);
            #1;
            chk("vec_resp_valid", 32'(resp_valid), 32'd1);
            chk("vec_resp_sum", resp_sum, vecs[v].exp_sum);
            chk("vec_resp_id", 32'(resp_id), 32'(vecs[v].r));
            $display("txn vec=%0d id=%0d sum=%h", v, resp_id, resp_sum);
        end

        // Both requesters valid continuously: grants alternate, one result per 3 cycles.
        @(negedge clk);
        sums_a[0] = 32'd2;
        sums_a[1] = 32'd7;
        set_req(0, 32'd1, 32'd1, 1'b0);
        set_req(1, 32'd10, 32'd3, 1'b1);
        req_valid  = 2'b11;
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_req_ready", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_idle_resp_valid", 32'(resp_valid), 32'd0);
            @(negedge clk);
            #1;
            chk("rr_exec_req_ready", 32'(req_ready), 32'd0);
            chk("rr_exec_resp_valid", 32'(resp_valid), 32'd0);
            @(negedge clk);
            #1;
            chk("rr_resp_valid", 32'(resp_valid), 32'd1);
            chk("rr_resp_id", 32'(resp_id), 32'(k % 2));
            chk("rr_resp_sum", resp_sum, sums_a[k % 2]);
            $display("txn rr=%0d id=%0d sum=%h", k, resp_id, resp_sum);
            @(negedge clk);
        end

        // Back-pressure in RESP for five cycles; req1 waits meanwhile.
        set_req(0, 32'd100, 32'd1, 1'b1);
        set_req(1, 32'd3, 32'd4, 1'b0);
        req_valid  = 2'b11;
        resp_ready = 1'b0;
        #1;
        chk("bp_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 2'b10;
        @(negedge clk);
        #1;
        held_sum = resp_sum;
        chk("bp_first_sum", held_sum, 32'd99);
        for (int c = 0; c < 5; c++) begin
            chk("bp_resp_valid", 32'(resp_valid), 32'd1);
            chk("bp_resp_sum", resp_sum, 32'd99);
            chk("bp_resp_id", 32'(resp_id), 32'd0);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_adder_in1", adder_in1, 32'd100);
            @(negedge clk);
            #1;
        end
        chk("bp_still_valid", 32'(resp_valid), 32'd1);
        $display("txn bp id=%0d sum=%h", resp_id, resp_sum);
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_after_resp_valid", 32'(resp_valid), 32'd0);
        chk("bp_next_grant", 32'(req_ready), 32'd2);

        // Reset during EXEC of the req1 operation discards it.
        @(negedge clk);
        set_req(0, 32'd20, 32'd5, 1'b1);
        reset     = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("mid_rst_adder_in1", adder_in1, 32'd0);
        end
        reset = 1'b0;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        chk("post_rst_exec_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("post_rst_resp_valid", 32'(resp_valid), 32'd1);
        chk("post_rst_resp_id", 32'(resp_id), 32'd0);
        chk("post_rst_resp_sum", resp_sum, 32'd15);
        $display("txn post_rst id=%0d sum=%h", resp_id, resp_sum);
        @(negedge clk);
        req_valid = 2'b00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
